// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcodes, imm_src encodings, immediate limits and request fields shared by the encoder
package instr_encoder_pkg;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_R = 2'b11;
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  typedef struct packed {
    logic [1:0]  imm_src;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;
endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational field packer and immediate range checker
module instr_pack
  import instr_encoder_pkg::*;
(
  input  fields_t     fields_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);
  logic signed [31:0] imm;
  assign imm = fields_i.imm;
  assign instr_o = fields_i.imm_src == IMM_I ? {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, OP_I}
    : fields_i.imm_src == IMM_S ? {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:0], OP_S}
    : fields_i.imm_src == IMM_B ? {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:1], imm[11], OP_B}
    : {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3, fields_i.rd, OP_R};
  assign illegal_o = fields_i.imm_src == IMM_R ? 1'b0
    : fields_i.imm_src == IMM_B ? (imm < IMM13_MIN || imm > IMM13_MAX || imm[0])
    : (imm < IMM12_MIN || imm > IMM12_MAX);
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready RISC-V instruction encoder with address and error counters
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        imm_src,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);
  fields_t           s1_q;
  logic              s1_valid_q, s2_valid_q, err_q;
  logic [31:0]       s2_instr_q, word;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              illegal, s1_load, s2_load, out_fire, drop_d, pass_d;
  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign out_fire  = s2_valid_q && out_ready;
  assign drop_d    = s2_load && s1_valid_q && illegal;
  assign pass_d    = s1_valid_q && !illegal;
  assign addr_d    = clr ? '0 : out_fire ? addr_q + ADDR_W'(1) : addr_q;
  assign err_cnt_d = clr ? '0 : (drop_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  instr_pack u_pack (
    .fields_i (s1_q),
    .instr_o  (word),
    .illegal_o(illegal)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (s1_load) s1_valid_q <= in_valid;
      if (s1_load && in_valid) s1_q <= '{imm_src: imm_src, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3, funct7: funct7, imm: imm_in};
      if (s2_load) s2_valid_q <= pass_d;
      if (s2_load && pass_d) s2_instr_q <= word;
      err_q     <= drop_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule
